supersonic_if: RTL and testbench

- Responder side of the controller's ranging handshake (trigger / triggerSuc / valid / distance).
- On a trigger request it fires the ultrasonic module's TRIG pin, measures the ECHO pulse width, converts it to millimetres and returns a one-cycle valid with the distance.
- Sits between the top-level controller and the HC-SR04-style sensor pins. Single 50 MHz clock domain; ECHO is asynchronous and is synchronised internally.

---
 rtl/supersonic_if_pkg.sv | 12 +
 rtl/supersonic_if_sync_2ff.sv | 15 +
 rtl/supersonic_if.sv | 118 +++++++++++
 tb/tb_supersonic_if.sv | 129 ++++++++++++
 4 files changed

// File: rtl/supersonic_if_pkg.sv
// supersonic_if_pkg: shared state encoding and 50 MHz timing defaults for the ultrasonic ranging interface
package supersonic_if_pkg;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE, HOLDOFF} state_t;
  localparam int TRIG_CYCLES_DEF = 500;
  localparam int DIV_CYCLES_DEF = 290;
  localparam int RISE_TIMEOUT_DEF = 1_500_000;
  localparam int HOLDOFF_CYCLES_DEF = 3_000_000;
  localparam int DIST_W_DEF = 17;
  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/supersonic_if_sync_2ff.sv
// sync_2ff: generic 1-bit two-flop synchroniser for asynchronous pin inputs
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q;
  logic [1:0] sync_d;
  always_comb sync_d = {sync_q[0], d};
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else sync_q <= sync_d;
  assign q = sync_q[1];
endmodule

// File: rtl/supersonic_if.sv
// supersonic_if: fires the sensor TRIG pin on request, times the ECHO pulse and returns the distance in mm
module supersonic_if
  import supersonic_if_pkg::*;
#(
  parameter int TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int DIV_CYCLES     = DIV_CYCLES_DEF,
  parameter int RISE_TIMEOUT   = RISE_TIMEOUT_DEF,
  parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF,
  parameter int DIST_W         = DIST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  output logic              triggerSuc,
  output logic              valid,
  output logic [DIST_W-1:0] distance,
  output logic              timeout,
  output logic              busy,
  output logic              sonic_trig,
  input  logic              sonic_echo
);
  localparam int CW = $clog2(max_of(max_of(TRIG_CYCLES + 1, RISE_TIMEOUT), HOLDOFF_CYCLES) + 1);
  localparam int PW = $clog2(DIV_CYCLES + 1);
  localparam logic [DIST_W-1:0] DMAX = '1;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [DIST_W-1:0] dist_q, dist_d, distance_q, distance_d;
  logic              trig_q, sonic_trig_q, sonic_trig_d, suc_q, suc_d;
  logic              valid_q, valid_d, timeout_q, timeout_d;
  logic              echo_s, req, wrap;
  sync_2ff u_echo_sync (.clk(clk), .rst(rst), .d(sonic_echo), .q(echo_s));
  assign req  = trigger & ~trig_q;
  assign wrap = presc_q == PW'(DIV_CYCLES - 1);
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    presc_d      = presc_q;
    dist_d       = dist_q;
    sonic_trig_d = 1'b0;
    suc_d        = 1'b0;
    valid_d      = 1'b0;
    distance_d   = distance_q;
    timeout_d    = timeout_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req) begin
          state_d   = TRIG;
          timeout_d = 1'b0;
        end
      end
      // first TRIG cycle only arms the pin, so it is high for exactly TRIG_CYCLES
      TRIG: begin
        sonic_trig_d = cnt_q != CW'(TRIG_CYCLES);
        if (cnt_q == CW'(TRIG_CYCLES)) begin
          state_d = WAIT_RISE;
          suc_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      WAIT_RISE: begin
        if (echo_s) begin
          state_d = MEASURE;
          presc_d = '0;
          dist_d  = '0;
        end else if (cnt_q == CW'(RISE_TIMEOUT - 1)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      // the falling-detect cycle is still counted: it accounts for the rise-detect cycle
      MEASURE: begin
        presc_d = wrap ? '0 : presc_q + 1'b1;
        dist_d  = (wrap && dist_q != DMAX) ? dist_q + 1'b1 : dist_q;
        state_d = echo_s ? MEASURE : DONE;
      end
      DONE: begin
        valid_d    = 1'b1;
        distance_d = timeout_q ? DMAX : dist_q;
        state_d    = HOLDOFF;
        cnt_d      = '0;
      end
      HOLDOFF: state_d = (cnt_q == CW'(HOLDOFF_CYCLES - 1)) ? IDLE : HOLDOFF;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      presc_q      <= '0;
      dist_q       <= '0;
      distance_q   <= '0;
      trig_q       <= 1'b0;
      sonic_trig_q <= 1'b0;
      suc_q        <= 1'b0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      presc_q      <= presc_d;
      dist_q       <= dist_d;
      distance_q   <= distance_d;
      trig_q       <= trigger;
      sonic_trig_q <= sonic_trig_d;
      suc_q        <= suc_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
    end
  assign triggerSuc = suc_q;
  assign valid      = valid_q;
  assign distance   = distance_q;
  assign timeout    = timeout_q;
  assign busy       = state_q != IDLE;
  assign sonic_trig = sonic_trig_q;
endmodule

// File: tb/tb_supersonic_if.sv
// tb_supersonic_if: directed and random ranging transactions checked against an arithmetic distance model
module tb_supersonic_if;
  localparam int T = 5, D = 4, R = 50, H = 20, W = 17, WS = 10;
  logic clk = 1'b0, rst = 1'b1, trigger = 1'b0, sonic_echo = 1'b0;
  logic trigger_suc, valid, timeout, busy, sonic_trig;
  logic [W-1:0] distance;
  logic s_suc, s_valid, s_timeout, s_busy, s_trig;
  logic [WS-1:0] s_distance;
  int errors = 0, checks = 0;
  always #10 clk = ~clk;
  supersonic_if #(.TRIG_CYCLES(T), .DIV_CYCLES(D), .RISE_TIMEOUT(R), .HOLDOFF_CYCLES(H), .DIST_W(W)) u_dut (
    .clk(clk), .rst(rst), .trigger(trigger), .triggerSuc(trigger_suc), .valid(valid),
    .distance(distance), .timeout(timeout), .busy(busy), .sonic_trig(sonic_trig), .sonic_echo(sonic_echo));
  supersonic_if #(.TRIG_CYCLES(T), .DIV_CYCLES(D), .RISE_TIMEOUT(R), .HOLDOFF_CYCLES(H), .DIST_W(WS)) u_sat (
    .clk(clk), .rst(rst), .trigger(trigger), .triggerSuc(s_suc), .valid(s_valid),
    .distance(s_distance), .timeout(s_timeout), .busy(s_busy), .sonic_trig(s_trig), .sonic_echo(sonic_echo));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic longint exp_dist(input int n, input int w, input bit echo);
    longint mx = (longint'(1) << w) - 1;
    if (!echo) return mx;
    return (n / D > mx) ? mx : longint'(n / D);
  endfunction
  task automatic run_meas(input int dly, input int width, input bit echo_en, input bit poke, input bit hold, input string tag);
    int c1, c2, c, lat, nval;
    logic [W-1:0] d_seen;
    logic t_seen;
    trigger = 1'b1;
    tick();
    if (!hold) trigger = 1'b0;
    chk({tag, " busy/timeout"}, {busy, timeout}, 2'b10);
    c1 = 0;
    while (!sonic_trig && c1 < 10) begin tick(); c1++; end
    c2 = 0;
    while (sonic_trig && c2 < 2 * T) begin tick(); c2++; end
    chk({tag, " trig width"}, c2, T);
    chk({tag, " suc latency"}, trigger_suc ? 1 + c1 + c2 : 0, T + 2);
    tick();
    chk({tag, " suc pulse"}, trigger_suc, 0);
    tick(dly);
    if (echo_en) begin
      sonic_echo = 1'b1;
      for (int i = 0; i < width; i++) begin
        tick();
        if (poke) trigger = (i == width / 2);
      end
      sonic_echo = 1'b0;
    end
    c = 0; lat = -1; nval = 0; d_seen = '0; t_seen = 1'b0;
    while (c < R + H + 30 && (lat < 0 || busy)) begin
      tick();
      c++;
      if (valid) begin
        nval++;
        if (lat < 0) begin
          lat = c;
          d_seen = distance;
          t_seen = timeout;
        end
      end
      if (poke && lat >= 0) trigger = (c == lat + 3);
    end
    chk({tag, " valid latency"}, lat, echo_en ? 4 : R);
    chk({tag, " valid count"}, nval, 1);
    chk({tag, " distance"}, d_seen, exp_dist(width, W, echo_en));
    chk({tag, " timeout"}, t_seen, !echo_en);
    chk({tag, " hold/idle"}, {distance, busy}, {d_seen, 1'b0});
  endtask
  initial begin
    int c, dly, width;
    tick(3);
    chk("reset outputs", {trigger_suc, valid, distance, timeout, busy, sonic_trig}, '0);
    rst = 1'b0;
    tick(2);
    run_meas(3, 40, 1'b1, 1'b0, 1'b0, "echo40");
    run_meas(3, 3602, 1'b1, 1'b0, 1'b0, "echo3602");
    run_meas(0, 0, 1'b0, 1'b0, 1'b0, "noecho");
    run_meas(5, 40, 1'b1, 1'b1, 1'b0, "poke");
    run_meas(4, 20, 1'b1, 1'b0, 1'b1, "held");
    c = 0;
    repeat (10) begin
      tick();
      if (sonic_trig || busy) c++;
    end
    chk("held no retrigger", c, 0);
    trigger = 1'b0;
    tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick(T + 4);
    sonic_echo = 1'b1;
    tick(10);
    rst = 1'b1;
    #1;
    chk("rst mid measure", {trigger_suc, valid, distance, timeout, busy, sonic_trig}, '0);
    tick(2);
    rst = 1'b0;
    sonic_echo = 1'b0;
    c = 0;
    repeat (30) begin
      tick();
      if (valid || busy) c++;
    end
    chk("rst no valid", c, 0);
    run_meas(2, 24, 1'b1, 1'b0, 1'b0, "post rst");
    for (int k = 0; k < 6; k++) begin
      dly = int'($urandom_range(0, 30));
      width = int'($urandom_range(1, 400));
      run_meas(dly, width, 1'b1, 1'b0, 1'b0, $sformatf("rand%0d", k));
    end
    run_meas(3, (1 << WS) * D + 10, 1'b1, 1'b0, 1'b0, "long");
    chk("saturated distance", s_distance, exp_dist((1 << WS) * D + 10, WS, 1'b1));
    chk("saturated idle", {s_suc, s_valid, s_timeout, s_busy, s_trig}, '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
